// File: rtl/mod_instruction_fetch.sv
// mod_instruction_fetch: single-outstanding-request instruction fetch stage.
// Cycles through IDLE -> REQ -> HOLD. In REQ it presents the PC to
// instruction memory and waits for imem_ready. In HOLD it keeps the fetched
// word until decode accepts it. On acceptance it applies jump/beq redirects.
// Optional feature macro: IF_FETCH_COUNT_EN adds a 32-bit fetch_count output
// that counts instructions accepted by decode.
module mod_instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero_flag,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] if_pc_plus4
`ifdef IF_FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcPlus4_q, pcPlus4_d;

  logic [31:0] jumpTarget;
  logic [31:0] branchOffset;
  logic [31:0] branchTarget;
  logic        redirect;
  logic        accept;

  // Redirect targets are derived from the held instruction; jump wins over branch
  always_comb begin
    jumpTarget   = {pcPlus4_q[31:28], instr_q[25:0], 2'b00};
    branchOffset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    branchTarget = pcPlus4_q + branchOffset;
    redirect     = jump | (branch & zero_flag);
  end

  // Next-state logic and Moore-style handshake outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d   = imem_rdata;
          pcPlus4_d = pc_q + 32'd4;
          pc_d      = pc_q + 32'd4;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if_valid = 1'b1;
        if (id_ready) begin
          accept  = 1'b1;
          state_d = REQ;
          if (jump) begin
            pc_d = jumpTarget;
          end else if (redirect) begin
            pc_d = branchTarget;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset overrides any in-flight fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      pcPlus4_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
    end
  end

  // Output views of the held instruction and current PC
  always_comb begin
    imem_addr   = pc_q;
    if_instr    = instr_q;
    if_pc_plus4 = pcPlus4_q;
    opcode      = instr_q[31:26];
    funct       = instr_q[5:0];
  end

`ifdef IF_FETCH_COUNT_EN
  logic [31:0] fetchCount_q;

  // Counts instructions handed to decode, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchCount_q <= 32'd0;
    end else if (accept) begin
      fetchCount_q <= fetchCount_q + 32'd1;
    end
  end

  assign fetch_count = fetchCount_q;
`else
  logic unusedAccept;
  assign unusedAccept = accept;
`endif

endmodule
